// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, select encoding, result-stage types.
package alu_pkg;

   localparam int ALU_IN_W  = 18;
   localparam int ALU_C_W   = 48;
   localparam int ALU_P_W   = 48;
   localparam int ALU_CNT_W = 8;

   // ALU 2-bit operation select
   localparam logic [1:0] ALU_SEL_ADD = 2'b00;
   localparam logic [1:0] ALU_SEL_SUB = 2'b01;
   localparam logic [1:0] ALU_SEL_MUL = 2'b10;
   localparam logic [1:0] ALU_SEL_MAC = 2'b11;

   // Group context of the result accumulator
   typedef enum logic {
      GRP_ACCUM = 1'b0,   // no beats of the current group accepted yet
      GRP_GROUP = 1'b1    // at least one non-last beat accumulated
   } grp_state_e;

   // Output FIFO entry at the default widths
   typedef struct packed {
      logic [ALU_P_W-1:0]   data;
      logic [ALU_CNT_W-1:0] count;
      logic                 ovf;
   } res_entry_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Small synchronous FIFO for finished group results; same-cycle push/pop.
// A push while full is dropped, even if a pop happens in the same cycle.
module alu_res_fifo
   import alu_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = res_entry_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  logic   pop,
   input  entry_t wdata,
   output entry_t rdata,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     occ;
   logic            do_push, do_pop;

   assign full    = (occ == (AW+1)'(DEPTH));
   assign empty   = (occ == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage write; contents need no reset since empty masks them
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers (wrap naturally, DEPTH is a power of two) and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_acc.sv
// ALU result accumulator: sums signed beats per in_last-terminated group,
// narrows the sum with overflow detection and queues {sum, count, ovf}.
// Build option ALU_ACC_SAT_EN: narrowing saturates instead of truncating.
// Assumes ACC_W > IN_DATA_W and ACC_W > OUT_DATA_W.
module alu_result_acc
   import alu_pkg::*;
#(
   parameter int IN_DATA_W  = 48,
   parameter int ACC_W      = 56,
   parameter int OUT_DATA_W = 48,
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_DATA_W-1:0]  in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]      out_count,
   output logic                  out_ovf
);

   typedef struct packed {
      logic [OUT_DATA_W-1:0] data;
      logic [CNT_W-1:0]      count;
      logic                  ovf;
   } entry_t;

   grp_state_e            state, state_nxt;
   logic [ACC_W-1:0]      acc, acc_base, in_sext, sum, narrow_sext;
   logic [OUT_DATA_W-1:0] narrow, sum_out;
   logic [CNT_W-1:0]      cnt, cnt_inc;
   logic                  cnt_sat, sat_inc;
   logic                  accept, ovf_sum, fifo_full, fifo_empty;
   entry_t                push_e, head_e;

   assign in_ready = !fifo_full;
   assign accept   = in_valid && in_ready;

   // Datapath: running sum including the current beat
   assign in_sext  = {{(ACC_W-IN_DATA_W){in_data[IN_DATA_W-1]}}, in_data};
   assign acc_base = (state == GRP_GROUP) ? acc : '0;
   assign sum      = acc_base + in_sext;

   // Beat count saturates; any beat past the maximum flags the group
   assign sat_inc  = (cnt == '1);
   assign cnt_inc  = sat_inc ? cnt : cnt + 1'b1;

   // Sum fits OUT_DATA_W iff sign-extending its low bits reproduces it
   assign narrow      = sum[OUT_DATA_W-1:0];
   assign narrow_sext = {{(ACC_W-OUT_DATA_W){narrow[OUT_DATA_W-1]}}, narrow};
   assign ovf_sum     = (narrow_sext != sum);

`ifdef ALU_ACC_SAT_EN
   // Clamp to the signed OUT_DATA_W range on overflow
   always_comb begin
      sum_out = narrow;
      if (ovf_sum)
         sum_out = sum[ACC_W-1] ? {1'b1, {(OUT_DATA_W-1){1'b0}}}
                                : {1'b0, {(OUT_DATA_W-1){1'b1}}};
   end
`else
   assign sum_out = narrow;
`endif

   assign push_e = '{data: sum_out, count: cnt_inc, ovf: ovf_sum | cnt_sat | sat_inc};

   // Group context register
   always_ff @(posedge clk) begin
      if (rst) state <= GRP_ACCUM;
      else     state <= state_nxt;
   end

   // Group context next state: open on a non-last beat, close on in_last
   always_comb begin
      state_nxt = state;
      if (accept) state_nxt = in_last ? GRP_ACCUM : GRP_GROUP;
   end

   // Accumulator and beat counter; cleared when the group closes
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         cnt_sat <= 1'b0;
      end else if (accept) begin
         if (in_last) begin
            acc     <= '0;
            cnt     <= '0;
            cnt_sat <= 1'b0;
         end else begin
            acc     <= sum;
            cnt     <= cnt_inc;
            cnt_sat <= cnt_sat | sat_inc;
         end
      end
   end

   alu_res_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept && in_last),
      .pop   (out_ready),
      .wdata (push_e),
      .rdata (head_e),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = out_valid ? head_e.data  : '0;
   assign out_count = out_valid ? head_e.count : '0;
   assign out_ovf   = out_valid ? head_e.ovf   : 1'b0;

endmodule

// File: tb/tb_alu_result_acc.sv
// Bench for alu_result_acc: directed groups with literal expectations plus a
// per-cycle compare against a queue-based group-sum model.
module tb_alu_result_acc;

   localparam int IW    = 48;
   localparam int AW    = 56;
   localparam int OW    = 48;
   localparam int CW    = 8;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [IW-1:0] in_data = '0;
   logic          in_ready, out_valid, out_ovf;
   logic [OW-1:0] out_data;
   logic [CW-1:0] out_count;

   int checks = 0;
   int passes = 0;

   typedef struct {
      longint data;
      longint count;
      bit     ovf;
   } exp_t;

   exp_t   q[$];
   longint run_sum = 0;
   int     run_beats = 0;
   bit     armed = 0;

   alu_result_acc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Expected FIFO entry for a finished group from its exact sum and beat total
   function automatic exp_t close_group(input longint s, input int beats);
      exp_t   e;
      longint w;
      longint maxo = (longint'(1) <<< (OW-1)) - 1;
      longint mino = -(longint'(1) <<< (OW-1));
      longint cmax = (longint'(1) <<< CW) - 1;
      w = (s <<< (64-AW)) >>> (64-AW);   // wrap modulo 2^AW, signed
      e.ovf   = (w > maxo) || (w < mino) || (longint'(beats) > cmax);
      e.count = (longint'(beats) > cmax) ? cmax : longint'(beats);
`ifdef ALU_ACC_SAT_EN
      if (w > maxo) w = maxo;
      if (w < mino) w = mino;
`endif
      e.data = w & ((longint'(1) <<< OW) - 1);
      return e;
   endfunction

   // Compare DUT against the model, then advance the model by the handshakes
   // that the next rising edge will perform
   always @(negedge clk) begin
      bit mv, mr;
      mv = (q.size() > 0);
      mr = (q.size() < DEPTH);
      if (armed) begin
         chk("out_valid", longint'(out_valid), longint'(mv));
         chk("in_ready", longint'(in_ready), longint'(mr));
         if (mv) begin
            chk("out_data", longint'(out_data), q[0].data);
            chk("out_count", longint'(out_count), q[0].count);
            chk("out_ovf", longint'(out_ovf), longint'(q[0].ovf));
         end
      end
      if (rst) begin
         q.delete();
         run_sum   = 0;
         run_beats = 0;
         armed     = 1;
      end else if (armed) begin
         if (mv && out_ready) void'(q.pop_front());
         if (in_valid && mr) begin
            run_sum += longint'($signed(in_data));
            run_beats++;
            if (in_last) begin
               q.push_back(close_group(run_sum, run_beats));
               run_sum   = 0;
               run_beats = 0;
            end
         end
      end
   end

   task automatic send(input logic [IW-1:0] d, input bit last);
      bit ok;
      ok = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checks++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1");
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic get_result(input string name, input logic [OW-1:0] d,
                             input logic [CW-1:0] c, input bit o);
      bit got;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = out_valid;
      end
      if (!got) begin
         checks++;
         $display("FAIL %s_timeout: out_valid stayed 0, required 1", name);
      end else begin
         chk({name, "_data"}, longint'(out_data), longint'(d));
         chk({name, "_count"}, longint'(out_count), longint'(c));
         chk({name, "_ovf"}, longint'(out_ovf), longint'(o));
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   initial begin
      logic [OW-1:0] ovf_exp;
      // Reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_out_count", longint'(out_count), 0);
      chk("rst_out_ovf", longint'(out_ovf), 0);
      @(posedge clk);
      #1;

      // Three-beat group: 16 + 32 - 16 = 32, visible the cycle after last
      send(48'h000000000010, 0);
      send(48'h000000000020, 0);
      send(48'hFFFFFFFFFFF0, 1);
      @(negedge clk);
      chk("lat_out_valid", longint'(out_valid), 1);
      get_result("grp3", 48'h000000000020, 8'd3, 1'b0);

      // Single-beat group
      send(48'h456789ABCDEF, 1);
      get_result("single", 48'h456789ABCDEF, 8'd1, 1'b0);

      // Overflow: 2 * (2^47-1) does not fit 48 signed bits
`ifdef ALU_ACC_SAT_EN
      ovf_exp = 48'h7FFFFFFFFFFF;
`else
      ovf_exp = 48'hFFFFFFFFFFFE;
`endif
      send(48'h7FFFFFFFFFFF, 0);
      send(48'h7FFFFFFFFFFF, 1);
      get_result("ovf", ovf_exp, 8'd2, 1'b1);

      // Backpressure: FIFO fills after two results, third beat is held
      send(48'd1, 1);
      send(48'd2, 1);
      in_valid = 1'b1;
      in_data  = 48'd3;
      in_last  = 1'b1;
      @(negedge clk);
      chk("bp_full_in_ready", longint'(in_ready), 0);
      @(negedge clk);
      chk("bp_full_in_ready2", longint'(in_ready), 0);
      get_result("bp1", 48'd1, 8'd1, 1'b0);
      @(negedge clk);
      chk("bp_reopen_in_ready", longint'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      get_result("bp2", 48'd2, 8'd1, 1'b0);
      get_result("bp3", 48'd3, 8'd1, 1'b0);
      @(negedge clk);
      chk("bp_drained", longint'(out_valid), 0);
      @(posedge clk);
      #1;

      // Count saturation: 300 beats of 1
      for (int i = 0; i < 299; i++) send(48'd1, 0);
      send(48'd1, 1);
      get_result("cnt_sat", 48'd300, 8'd255, 1'b1);

      // Reset mid-group discards the partial sum and the queued result
      send(48'd9, 1);
      send(48'd5, 0);
      send(48'd5, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rstmid_out_valid", longint'(out_valid), 0);
      @(posedge clk);
      #1;
      send(48'd7, 1);
      get_result("rstmid", 48'd7, 8'd1, 1'b0);
      @(negedge clk);
      chk("rstmid_no_stale", longint'(out_valid), 0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
